spi_stack_router: RTL and testbench

Successor to the single-channel SPI stack. It combines an SPI minion frame engine, a request FIFO, a per-channel loopthrough and a round-robin response arbiter. A host drives framed SPI transactions, and each frame carries a channel ID. The block routes each request to one of `nchan` downstream val/rdy channels, or loops it straight back to the host when that channel's loopthrough bit is set. Responses are tagged with the channel ID and buffered for return on later frames.

---
 rtl/spi_stack_router.sv | 234 +++++++++++++++++++++++
 tb/tb_spi_stack_router.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_stack_router.sv
// SPI minion front end that routes framed requests to nchan val/rdy channels (or loops
// them back) and returns channel-tagged responses through a round-robin arbiter.

module spi_stack_fifo #(
  parameter int W = 8,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int AW = (D > 1) ? $clog2(D) : 1;
  localparam int CW = $clog2(D + 1);

  logic [W-1:0]  mem [D];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(D));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rptr];

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(D - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= next_ptr(wptr);
      if (do_pop)  rptr <= next_ptr(rptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end
endmodule

module spi_stack_router #(
  parameter  int nbits = 34,
  parameter  int nchan = 4,
  parameter  int depth = 2,
  localparam int cbits = $clog2(nchan),
  localparam int pbits = nbits - 2,
  localparam int dbits = pbits - cbits
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [nchan-1:0]       loopthrough_sel,
  input  logic                   sclk,
  input  logic                   cs,
  input  logic                   mosi,
  output logic                   miso,
  output logic [nchan-1:0]       send_val,
  output logic [dbits-1:0]       send_msg,
  input  logic [nchan-1:0]       send_rdy,
  input  logic [nchan-1:0]       recv_val,
  input  logic [nchan*dbits-1:0] recv_msg,
  output logic [nchan-1:0]       recv_rdy,
  output logic                   frame_err
);
  localparam int abits = $clog2(nchan + 1);
  localparam int cntw  = $clog2(nbits + 2);
  localparam logic [cntw-1:0] CNT_FULL = cntw'(nbits);
  localparam logic [cntw-1:0] CNT_MAX  = cntw'(nbits + 1);

  logic [1:0]       sclk_sync, cs_sync, mosi_sync;
  logic             sclk_q, cs_q;
  logic             sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic             in_frame, adv_val, adv_spc;
  logic [cntw-1:0]  bit_cnt;
  logic [nbits-1:0] rx_sr, tx_sr;
  logic             frame_end, cnt_ok, req_push, req_drop, resp_pop;

  logic             req_pop, req_empty, req_full;
  logic [pbits-1:0] req_head;
  logic [cbits-1:0] head_chan;
  logic             chan_bad, head_loop, loop_req, loop_gnt, err_disp;

  logic             resp_push, resp_empty, resp_full;
  logic [pbits-1:0] resp_din, resp_head;
  logic [nchan:0]   req_vec;
  logic [abits-1:0] rr_ptr, gnt_idx, arb_idx;
  logic [abits:0]   arb_sum;
  logic             gnt_any, xfer;

  // Pin synchronizers and edge detect
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk};
      cs_sync   <= {cs_sync[0], cs};
      mosi_sync <= {mosi_sync[0], mosi};
      sclk_q    <= sclk_sync[1];
      cs_q      <= cs_sync[1];
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_q;
  assign sclk_fall = ~sclk_sync[1] & sclk_q;
  // A cs fall needs cs_q high, so after reset nothing starts until cs has been seen high.
  assign cs_fall   = ~cs_sync[1] & cs_q;
  assign cs_rise   = cs_sync[1] & ~cs_q;

  // Frame engine
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_frame <= 1'b0;
      bit_cnt  <= '0;
      tx_sr    <= '0;
      adv_val  <= 1'b0;
      adv_spc  <= 1'b0;
    end else if (cs_fall) begin
      in_frame <= 1'b1;
      bit_cnt  <= '0;
      tx_sr    <= {~resp_empty, ~req_full, resp_empty ? {pbits{1'b0}} : resp_head};
      adv_val  <= ~resp_empty;
      adv_spc  <= ~req_full;
    end else if (cs_rise) begin
      in_frame <= 1'b0;
    end else if (in_frame) begin
      if (sclk_rise && bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 1'b1;
      if (sclk_fall) tx_sr <= {tx_sr[nbits-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (in_frame && sclk_rise) rx_sr <= {rx_sr[nbits-2:0], mosi_sync[1]};
  end

  assign miso      = tx_sr[nbits-1];
  assign frame_end = cs_rise & in_frame;
  assign cnt_ok    = (bit_cnt == CNT_FULL);
  assign req_push  = frame_end & cnt_ok & rx_sr[nbits-1] & adv_spc;
  assign req_drop  = frame_end & cnt_ok & rx_sr[nbits-1] & ~adv_spc;
  assign resp_pop  = frame_end & cnt_ok & rx_sr[nbits-2] & adv_val;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) frame_err <= 1'b0;
    else        frame_err <= (frame_end & ~cnt_ok) | req_drop | err_disp;
  end

  spi_stack_fifo #(.W(pbits), .D(depth)) u_req_fifo (
    .clk(clk), .reset(reset), .push(req_push), .din(rx_sr[pbits-1:0]),
    .pop(req_pop), .dout(req_head), .empty(req_empty), .full(req_full)
  );

  // Request dispatch
  assign head_chan = req_head[pbits-1 -: cbits];
  assign send_msg  = req_head[dbits-1:0];
  assign chan_bad  = ({1'b0, head_chan} >= (cbits + 1)'(nchan));
  assign head_loop = loopthrough_sel[head_chan];
  assign loop_req  = ~req_empty & ~chan_bad & head_loop;

  always_comb begin
    send_val = '0;
    req_pop  = 1'b0;
    err_disp = 1'b0;
    if (!req_empty) begin
      if (chan_bad) begin
        req_pop  = 1'b1;
        err_disp = 1'b1;
      end else if (head_loop) begin
        req_pop = loop_gnt;
      end else begin
        send_val[head_chan] = 1'b1;
        req_pop             = send_rdy[head_chan];
      end
    end
  end

  // Round-robin response arbiter; index nchan is the loopback requester
  assign req_vec = {loop_req, recv_val};

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    arb_sum = '0;
    arb_idx = '0;
    for (int k = 0; k <= nchan; k++) begin
      arb_sum = {1'b0, rr_ptr} + (abits + 1)'(k);
      if (arb_sum > (abits + 1)'(nchan)) arb_sum = arb_sum - (abits + 1)'(nchan + 1);
      arb_idx = arb_sum[abits-1:0];
      if (!gnt_any && req_vec[arb_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = arb_idx;
      end
    end
  end

  assign xfer      = gnt_any & ~resp_full;
  assign resp_push = xfer;
  assign loop_gnt  = xfer & (gnt_idx == abits'(nchan));

  always_comb begin
    recv_rdy = '0;
    resp_din = req_head;
    for (int c = 0; c < nchan; c++) begin
      if (gnt_idx == abits'(c)) begin
        recv_rdy[c] = xfer;
        resp_din    = {cbits'(c), recv_msg[c*dbits +: dbits]};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    rr_ptr <= '0;
    else if (xfer) rr_ptr <= (gnt_idx == abits'(nchan)) ? '0 : gnt_idx + 1'b1;
  end

  spi_stack_fifo #(.W(pbits), .D(depth)) u_resp_fifo (
    .clk(clk), .reset(reset), .push(resp_push), .din(resp_din),
    .pop(resp_pop), .dout(resp_head), .empty(resp_empty), .full(resp_full)
  );
endmodule

// File: tb/tb_spi_stack_router.sv
// Bench for spi_stack_router: directed scenarios plus random frames/drains/responses
// checked against a queue-based transaction model.

module tb_spi_stack_router;
  localparam int NBITS = 34;
  localparam int NCHAN = 4;
  localparam int DEPTH = 2;
  localparam int CBITS = 2;
  localparam int PBITS = NBITS - 2;
  localparam int DBITS = PBITS - CBITS;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic [NCHAN-1:0]       loopthrough_sel = '0;
  logic                   sclk = 1'b0, cs = 1'b1, mosi = 1'b0;
  logic                   miso;
  logic [NCHAN-1:0]       send_val;
  logic [DBITS-1:0]       send_msg;
  logic [NCHAN-1:0]       send_rdy = '0;
  logic [NCHAN-1:0]       recv_val = '0;
  logic [NCHAN*DBITS-1:0] recv_msg = '0;
  logic [NCHAN-1:0]       recv_rdy;
  logic                   frame_err;

  spi_stack_router #(.nbits(NBITS), .nchan(NCHAN), .depth(DEPTH)) dut (
    .clk(clk), .reset(reset), .loopthrough_sel(loopthrough_sel),
    .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
    .send_val(send_val), .send_msg(send_msg), .send_rdy(send_rdy),
    .recv_val(recv_val), .recv_msg(recv_msg), .recv_rdy(recv_rdy),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  int err_seen = 0;
  int sv_cycles = 0;

  always @(posedge clk) begin
    if (frame_err === 1'b1) err_seen++;
    if (send_val !== '0) sv_cycles++;
  end

  logic [PBITS-1:0] m_req[$];
  logic [PBITS-1:0] m_resp[$];
  logic [NCHAN-1:0] m_sel;
  int               exp_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int chan_of(input logic [PBITS-1:0] p);
    return int'(p[PBITS-1 -: CBITS]);
  endfunction

  // Looped-back heads move to the response queue whenever it has room.
  task automatic settle();
    while (m_req.size() > 0 && m_sel[chan_of(m_req[0])] && m_resp.size() < DEPTH)
      m_resp.push_back(m_req.pop_front());
  endtask

  task automatic check_dispatch(input string tag);
    logic [NCHAN-1:0] exp_sv;
    exp_sv = '0;
    if (m_req.size() > 0 && !m_sel[chan_of(m_req[0])]) exp_sv[chan_of(m_req[0])] = 1'b1;
    chk({tag, "_send_val"}, send_val, exp_sv);
    if (exp_sv != '0) chk({tag, "_send_msg"}, send_msg, m_req[0][DBITS-1:0]);
    chk({tag, "_frame_err"}, err_seen, exp_err);
  endtask

  task automatic do_reset();
    reset = 1'b0; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    send_rdy = '0; recv_val = '0;
    clks(3);
    reset = 1'b1;
    clks(4);
    m_req.delete();
    m_resp.delete();
  endtask

  task automatic spi_bits(input logic [NBITS-1:0] word, input int first, input int nb,
                          inout logic [NBITS-1:0] got);
    for (int i = first; i < first + nb; i++) begin
      mosi = (i < NBITS) ? word[NBITS-1-i] : 1'b0;
      clks(6);
      sclk = 1'b1;
      if (i < NBITS) got[NBITS-1-i] = miso;
      clks(6);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_frame(input logic [NBITS-1:0] word, input int nb, output logic [NBITS-1:0] got);
    got = '0;
    cs = 1'b0;
    clks(6);
    spi_bits(word, 0, nb, got);
    clks(6);
    cs = 1'b1;
    clks(10);
  endtask

  task automatic host_frame(input logic v, input logic s, input logic [PBITS-1:0] pl,
                            input int nb, output logic [NBITS-1:0] got);
    logic [NBITS-1:0] exp;
    exp = {m_resp.size() > 0, m_req.size() < DEPTH,
           (m_resp.size() > 0) ? m_resp[0] : {PBITS{1'b0}}};
    spi_frame({v, s, pl}, nb, got);
    if (nb >= NBITS) chk("miso", got, exp);
    else             chk("miso_short", got >> (NBITS - nb), exp >> (NBITS - nb));
    if (nb != NBITS) exp_err++;
    else begin
      if (v) begin
        if (m_req.size() < DEPTH) m_req.push_back(pl);
        else exp_err++;
      end
      if (s && m_resp.size() > 0) void'(m_resp.pop_front());
    end
    settle();
    check_dispatch("frame");
  endtask

  task automatic pulse_rdy(input int c);
    send_rdy[c] = 1'b1;
    clks(1);
    send_rdy = '0;
    clks(2);
  endtask

  task automatic drain();
    int c;
    if (m_req.size() > 0 && !m_sel[chan_of(m_req[0])]) begin
      c = chan_of(m_req[0]);
      pulse_rdy(c);
      void'(m_req.pop_front());
      settle();
    end else begin
      pulse_rdy(int'($urandom_range(0, NCHAN-1)));
    end
    check_dispatch("drain");
  endtask

  task automatic wrong_rdy();
    int c;
    c = int'($urandom_range(0, NCHAN-1));
    if (m_req.size() > 0 && !m_sel[chan_of(m_req[0])] && c == chan_of(m_req[0]))
      c = (c + 1) % NCHAN;
    pulse_rdy(c);
    check_dispatch("wrong_rdy");
  endtask

  task automatic inject(input int c, input logic [DBITS-1:0] d);
    logic             is_full;
    logic [NCHAN-1:0] exp_rdy;
    is_full = (m_resp.size() >= DEPTH);
    exp_rdy = '0;
    if (!is_full) exp_rdy[c] = 1'b1;
    recv_msg[c*DBITS +: DBITS] = d;
    recv_val[c] = 1'b1;
    #1;
    chk("recv_rdy", recv_rdy, exp_rdy);
    clks(1);
    recv_val = '0;
    clks(2);
    if (!is_full) m_resp.push_back({CBITS'(c), d});
    settle();
    check_dispatch("inject");
  endtask

  logic [NBITS-1:0] got;
  logic [DBITS-1:0] fd [NCHAN];
  int               sv_before, kind, nb;

  initial begin
    // Reset state
    reset = 1'b0;
    clks(3);
    chk("rst_miso", miso, 0);
    chk("rst_send_val", send_val, 0);
    chk("rst_recv_rdy", recv_rdy, 0);
    chk("rst_frame_err", frame_err, 0);
    m_sel = '0; loopthrough_sel = '0;
    do_reset();
    check_dispatch("post_reset");

    // Request routing
    host_frame(1'b1, 1'b0, {2'd2, 30'h1234}, NBITS, got);
    chk("route_send_val", send_val, 4'b0100);
    chk("route_send_msg", send_msg, 30'h1234);
    clks(20);
    chk("route_hold", send_val, 4'b0100);
    host_frame(1'b0, 1'b0, '0, NBITS, got);
    chk("route_next_spc", got[NBITS-2], 1'b1);
    drain();
    chk("route_done", send_val, 4'b0000);

    // Loopback
    do_reset();
    m_sel = 4'b0001; loopthrough_sel = 4'b0001;
    sv_before = sv_cycles;
    host_frame(1'b1, 1'b0, {2'd0, 30'hAB}, NBITS, got);
    host_frame(1'b0, 1'b1, '0, NBITS, got);
    chk("loop_miso", got, {2'b11, 2'd0, 30'hAB});
    host_frame(1'b0, 1'b0, '0, NBITS, got);
    chk("loop_resp_empty", got[NBITS-1], 1'b0);
    chk("loop_no_send_val", sv_cycles - sv_before, 0);

    // Arbitration fairness
    do_reset();
    m_sel = '0; loopthrough_sel = '0;
    for (int c = 0; c < NCHAN; c++) begin
      fd[c] = DBITS'(32'h0ABC_0000 + 32'(c) * 17);
      recv_msg[c*DBITS +: DBITS] = fd[c];
    end
    recv_val = 4'b1111;
    clks(4);
    chk("fair_full_rdy", recv_rdy, 4'b0000);
    for (int k = 0; k < 6; k++) begin
      spi_frame({2'b01, 32'h0}, NBITS, got);
      chk("fair_order", got, {2'b11, CBITS'(k % NCHAN), fd[k % NCHAN]});
      chk("fair_full_rdy", recv_rdy, 4'b0000);
    end
    recv_val = '0;

    // Request overflow
    do_reset();
    host_frame(1'b1, 1'b0, {2'd2, 30'h111}, NBITS, got);
    host_frame(1'b1, 1'b0, {2'd3, 30'h222}, NBITS, got);
    host_frame(1'b1, 1'b0, {2'd1, 30'h333}, NBITS, got);
    chk("ovf_spc", got[NBITS-2], 1'b0);
    drain();
    drain();
    chk("ovf_empty", send_val, 4'b0000);

    // Short frame then a normal one
    host_frame(1'b1, 1'b0, {2'd1, 30'h3_0000}, 20, got);
    host_frame(1'b1, 1'b0, {2'd1, 30'h4_0000}, NBITS, got);
    drain();

    // Reset in the middle of a frame
    host_frame(1'b1, 1'b0, {2'd1, 30'h155}, NBITS, got);
    cs = 1'b0;
    clks(6);
    got = '0;
    spi_bits({2'b10, 2'd3, 30'h2AA}, 0, 10, got);
    reset = 1'b0;
    #1;
    chk("midrst_miso", miso, 0);
    chk("midrst_send_val", send_val, 0);
    chk("midrst_recv_rdy", recv_rdy, 0);
    chk("midrst_frame_err", frame_err, 0);
    clks(3);
    reset = 1'b1;
    m_req.delete();
    m_resp.delete();
    spi_bits({2'b10, 2'd3, 30'h2AA}, 10, NBITS - 10, got);
    clks(6);
    cs = 1'b1;
    clks(10);
    check_dispatch("midrst_after");
    host_frame(1'b1, 1'b0, {2'd3, 30'h2AA}, NBITS, got);
    chk("midrst_push", send_val, 4'b1000);

    // Random traffic against the model
    do_reset();
    m_sel = 4'($urandom);
    loopthrough_sel = m_sel;
    for (int it = 0; it < 110; it++) begin
      kind = int'($urandom_range(0, 9));
      if (kind <= 4) begin
        nb = NBITS;
        if ($urandom_range(0, 9) == 0) nb = (kind == 0) ? 20 : ((kind == 1) ? 33 : 35);
        case ($urandom_range(0, 2))
          0:       host_frame(1'b1, 1'b0, PBITS'($urandom), nb, got);
          1:       host_frame(1'b0, 1'b1, PBITS'($urandom), nb, got);
          default: host_frame(1'b0, 1'b0, PBITS'($urandom), nb, got);
        endcase
      end else if (kind <= 6) begin
        drain();
      end else if (kind <= 8) begin
        inject(int'($urandom_range(0, NCHAN-1)), DBITS'($urandom));
      end else begin
        wrong_rdy();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
